// File: rtl/print_pkg.sv
// Shared types and character constants for the printer queue.
package print_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_e;

    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    function automatic logic is_newline(input logic [7:0] b);
        return (b == ASCII_LF) || (b == ASCII_CR);
    endfunction

endpackage

// File: rtl/print_queue_if.sv
// Character-in / transmitter-out bundle of the print queue.
interface print_queue_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned LevelW = $clog2(DEPTH) + 1;

    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic              flush;
    logic [7:0]        byte_out;
    logic              set_byte;
    logic              done;
    logic [LevelW-1:0] level;
    logic              busy;

    // master: keyboard/host plus transmitter side; slave: the queue itself
    modport master (
        output char_in, char_valid, flush, done,
        input  char_ready, byte_out, set_byte, level, busy
    );

    modport slave (
        input  char_in, char_valid, flush, done,
        output char_ready, byte_out, set_byte, level, busy
    );

endinterface

// File: rtl/print_queue_byte_fifo.sv
// Byte FIFO with occupancy count; flush has priority over push and pop.
module byte_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AddrW = $clog2(DEPTH),
    localparam int unsigned LevelW = AddrW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    input  logic              flush,
    output logic [7:0]        dout,
    output logic [LevelW-1:0] level,
    output logic              full,
    output logic              empty
);

    logic [7:0]        mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LevelW-1:0] count_q;
    logic              do_push, do_pop;

    assign full    = (count_q == LevelW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem_q[rd_ptr_q];
    assign level   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // pointers wrap naturally because DEPTH is a power of two
            if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            count_q <= count_q + LevelW'(do_push) - LevelW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/print_queue.sv
// Buffers characters for the serial printer, inserts automatic line feeds at
// LINE_WIDTH columns and paces bytes with an idle gap after each done.
module print_queue import print_pkg::*; #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned LINE_WIDTH = 32,
    parameter int unsigned GAP_CYCLES = 50000
) (
    input logic         clk,
    input logic         rst,
    print_queue_if.slave bus
);

    localparam int unsigned LevelW  = $clog2(DEPTH) + 1;
    localparam int unsigned ColW    = $clog2(LINE_WIDTH + 1);
    localparam int unsigned GapW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int unsigned GapLast = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_e            state_q, state_d;
    logic [7:0]        byte_q, byte_d;
    logic              pending_lf_q, pending_lf_d;
    logic [ColW-1:0]   column_q, column_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              pop;
    logic [7:0]        head;
    logic [LevelW-1:0] fifo_level;
    logic              fifo_full, fifo_empty;

    byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.char_valid),
        .din   (bus.char_in),
        .pop   (pop),
        .flush (bus.flush),
        .dout  (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= 8'h00;
            pending_lf_q <= 1'b0;
            column_q     <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            pending_lf_q <= pending_lf_d;
            column_q     <= column_d;
            gap_q        <= gap_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        pending_lf_d = pending_lf_q;
        column_d     = column_q;
        gap_d        = gap_q;
        pop          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty || pending_lf_q) begin
                    state_d = S_SEND;
                    if (pending_lf_q) begin
                        byte_d = ASCII_LF;
                    end else if (column_q == ColW'(LINE_WIDTH) && head != ASCII_LF) begin
                        // head stays queued; it follows the inserted LF
                        byte_d       = ASCII_LF;
                        pending_lf_d = 1'b1;
                    end else begin
                        byte_d = head;
                        pop    = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (bus.done) begin
                    state_d      = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                    pending_lf_d = 1'b0;
                    if (is_newline(byte_q)) begin
                        column_d = '0;
                    end else if (byte_q >= ASCII_SPACE && column_q != ColW'(LINE_WIDTH)) begin
                        column_d = column_q + ColW'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GapW'(GapLast)) begin
                    gap_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.char_ready = !fifo_full;
    assign bus.byte_out   = byte_q;
    assign bus.set_byte   = (state_q == S_SEND);
    assign bus.level      = fifo_level;
    assign bus.busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_print_queue.sv
// Self-checking bench for print_queue against a stream-level reference model.
module tb_print_queue;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned LINE_WIDTH = 4;
    localparam int unsigned GAP_CYCLES = 6;
    localparam int unsigned LVLW       = $clog2(DEPTH) + 1;
    localparam logic [16:0] RESET_VEC  = {1'b1, 1'b0, 8'h00, 5'd0, 1'b0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    print_queue_if #(.DEPTH(DEPTH)) bus();

    print_queue #(
        .DEPTH      (DEPTH),
        .LINE_WIDTH (LINE_WIDTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: accepted-but-unprinted bytes plus the printed column.
    logic [7:0] in_q[$];
    int         m_col;
    logic [7:0] obs_q[$];

    function automatic void model_next(output logic [7:0] b, output int lvl);
        if (m_col == LINE_WIDTH && in_q.size() > 0 && in_q[0] != 8'h0A) begin
            b     = 8'h0A;
            m_col = 0;
        end else begin
            b = in_q.pop_front();
            if (b == 8'h0A || b == 8'h0D) m_col = 0;
            else if (b >= 8'h20 && m_col < LINE_WIDTH) m_col++;
        end
        lvl = in_q.size();
    endfunction

    function automatic logic [16:0] out_vec();
        return {bus.char_ready, bus.set_byte, bus.byte_out, bus.level, bus.busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_in    = 8'h00;
        bus.flush      = 1'b0;
        bus.done       = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        in_q.delete();
        obs_q.delete();
        m_col = 0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc = 1'b0;
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = bus.char_ready;
            tick();
        end
        bus.char_valid = 1'b0;
        total++;
        if (!acc) $display("FAIL push_accept: byte %h never accepted (ready stayed 0)", b);
        else begin
            passed++;
            in_q.push_back(b);
        end
    endtask

    task automatic serve(input bit chk_lvl, input int hold_max);
        logic [7:0] eb;
        int         el;
        bit         seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.set_byte === 1'b1) seen = 1'b1;
            else tick();
        end
        total++;
        if (!seen) begin
            $display("FAIL serve_wait: set_byte=%b after 200 cycles, required 1", bus.set_byte);
            return;
        end
        passed++;
        model_next(eb, el);
        obs_q.push_back(bus.byte_out);
        total++;
        if (bus.byte_out !== eb) $display("FAIL byte_out: got %h, required %h", bus.byte_out, eb);
        else passed++;
        if (chk_lvl) begin
            total++;
            if (bus.level !== LVLW'(el))
                $display("FAIL level_at_send: got %0d, required %0d", bus.level, el);
            else passed++;
        end
        repeat ($urandom_range(hold_max, 0)) tick();
        total++;
        if (bus.set_byte !== 1'b1 || bus.byte_out !== eb)
            $display("FAIL hold: set_byte=%b byte_out=%h, required 1/%h",
                     bus.set_byte, bus.byte_out, eb);
        else passed++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        total++;
        if (bus.set_byte !== 1'b0) $display("FAIL drop_after_done: set_byte=%b, required 0",
                                            bus.set_byte);
        else passed++;
    endtask

    task automatic serve_all(input bit chk_lvl, input int hold_max);
        for (int k = 0; k < 64 && in_q.size() > 0; k++) serve(chk_lvl, hold_max);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (out_vec() !== RESET_VEC) $display("FAIL reset_values: got %h, required %h",
                                              out_vec(), RESET_VEC);
        else passed++;
    endtask

    task automatic test_single();
        logic [7:0] eb;
        int         el;
        bit         ok;
        do_reset();
        bus.char_in    = 8'h41;
        bus.char_valid = 1'b1;
        tick();
        bus.char_valid = 1'b0;
        in_q.push_back(8'h41);
        total++;
        if (bus.level !== LVLW'(1) || bus.set_byte !== 1'b0)
            $display("FAIL latency_n: level=%0d set_byte=%b, required 1/0", bus.level, bus.set_byte);
        else passed++;
        tick();
        model_next(eb, el);
        total++;
        if (bus.set_byte !== 1'b1 || bus.byte_out !== eb || bus.level !== LVLW'(el) ||
            bus.busy !== 1'b1)
            $display("FAIL latency_n1: set=%b byte=%h level=%0d busy=%b, required 1/%h/%0d/1",
                     bus.set_byte, bus.byte_out, bus.level, bus.busy, eb, el);
        else passed++;
        ok = 1'b1;
        repeat (100) begin
            tick();
            if (bus.set_byte !== 1'b1 || bus.byte_out !== eb) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL stall_stable: set=%b byte=%h, required 1/%h",
                          bus.set_byte, bus.byte_out, eb);
        else passed++;
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        total++;
        if (bus.set_byte !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL after_done: set=%b busy=%b, required 0/1", bus.set_byte, bus.busy);
        else passed++;
        ok = 1'b1;
        for (int i = 1; i < GAP_CYCLES; i++) begin
            tick();
            if (bus.busy !== 1'b1 || bus.set_byte !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL gap_busy: busy=%b set=%b, required 1/0", bus.busy, bus.set_byte);
        else passed++;
        tick();
        total++;
        if (bus.busy !== 1'b0 || bus.level !== LVLW'(0))
            $display("FAIL gap_end: busy=%b level=%0d, required 0/0", bus.busy, bus.level);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] last;
        for (int i = 0; i < 17; i++) push_byte(8'($urandom_range(8'h7E, 8'h21)));
        total++;
        if (bus.level !== LVLW'(DEPTH) || bus.char_ready !== 1'b0)
            $display("FAIL full: level=%0d ready=%b, required %0d/0",
                     bus.level, bus.char_ready, DEPTH);
        else passed++;
        last           = 8'($urandom_range(8'h7E, 8'h21));
        bus.char_in    = last;
        bus.char_valid = 1'b1;
        repeat (5) tick();
        total++;
        if (bus.level !== LVLW'(DEPTH) || bus.char_ready !== 1'b0)
            $display("FAIL full_refuse: level=%0d ready=%b, required %0d/0",
                     bus.level, bus.char_ready, DEPTH);
        else passed++;
        fork
            push_byte(last);
            serve_all(1'b0, 3);
        join
        total++;
        if (bus.level !== LVLW'(0) || in_q.size() != 0)
            $display("FAIL drain: level=%0d model_left=%0d, required 0/0", bus.level, in_q.size());
        else passed++;
    endtask

    task automatic test_line_wrap();
        logic [7:0] exp_seq [6] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0A, 8'h45};
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'h41 + 8'(i));
        serve_all(1'b1, 2);
        ok = (obs_q.size() == 6);
        for (int i = 0; i < 6 && ok; i++) if (obs_q[i] !== exp_seq[i]) ok = 1'b0;
        total++;
        if (!ok) $display("FAIL line_wrap: got %p, required %p", obs_q, exp_seq);
        else passed++;
    endtask

    task automatic test_lf_no_insert();
        logic [7:0] exp_a [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
        logic [7:0] exp_b [6] = '{8'h57, 8'h58, 8'h59, 8'h5A, 8'h0A, 8'h51};
        logic [7:0] src_b [5] = '{8'h57, 8'h58, 8'h59, 8'h5A, 8'h51};
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(exp_a[i]);
        serve_all(1'b1, 2);
        ok = (obs_q.size() == 5);
        for (int i = 0; i < 5 && ok; i++) if (obs_q[i] !== exp_a[i]) ok = 1'b0;
        total++;
        if (!ok) $display("FAIL lf_no_insert: got %p, required %p", obs_q, exp_a);
        else passed++;
        obs_q.delete();
        for (int i = 0; i < 5; i++) push_byte(src_b[i]);
        serve_all(1'b1, 2);
        ok = (obs_q.size() == 6);
        for (int i = 0; i < 6 && ok; i++) if (obs_q[i] !== exp_b[i]) ok = 1'b0;
        total++;
        if (!ok) $display("FAIL column_cleared: got %p, required %p", obs_q, exp_b);
        else passed++;
    endtask

    task automatic test_flush();
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(8'h31 + 8'(i));
        bus.flush      = 1'b1;
        bus.char_in    = 8'h5A;
        bus.char_valid = 1'b1;
        tick();
        bus.flush      = 1'b0;
        bus.char_valid = 1'b0;
        total++;
        if (bus.level !== LVLW'(0) || bus.set_byte !== 1'b1 || bus.byte_out !== 8'h31)
            $display("FAIL flush_edge: level=%0d set=%b byte=%h, required 0/1/31",
                     bus.level, bus.set_byte, bus.byte_out);
        else passed++;
        serve(1'b0, 2);
        in_q.delete();
        ok = 1'b1;
        repeat (GAP_CYCLES + 30) begin
            tick();
            if (bus.set_byte !== 1'b0 || bus.level !== LVLW'(0)) ok = 1'b0;
        end
        total++;
        if (!ok || bus.busy !== 1'b0)
            $display("FAIL after_flush: set=%b level=%0d busy=%b, required 0/0/0",
                     bus.set_byte, bus.level, bus.busy);
        else passed++;
    endtask

    task automatic test_reset_mid_send();
        bit seen = 1'b0;
        bit ok;
        push_byte(8'h61);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.set_byte === 1'b1) seen = 1'b1;
            else tick();
        end
        total++;
        if (!seen) $display("FAIL mid_send_wait: set_byte=%b, required 1", bus.set_byte);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (out_vec() !== RESET_VEC) $display("FAIL async_reset: got %h, required %h",
                                              out_vec(), RESET_VEC);
        else passed++;
        tick();
        rst = 1'b0;
        in_q.delete();
        m_col = 0;
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        ok = (out_vec() === RESET_VEC);
        repeat (3) begin
            tick();
            if (out_vec() !== RESET_VEC) ok = 1'b0;
        end
        total++;
        if (!ok) $display("FAIL stray_done: got %h, required %h", out_vec(), RESET_VEC);
        else passed++;
    endtask

    task automatic test_random();
        logic [7:0] b;
        int         r;
        for (int round = 0; round < 8; round++) begin
            obs_q.delete();
            for (int i = 0, n = $urandom_range(DEPTH, 1); i < n; i++) begin
                r = $urandom_range(9, 0);
                if (r == 0)      b = 8'h0A;
                else if (r == 1) b = 8'h0D;
                else if (r == 2) b = 8'($urandom_range(8'h1F, 8'h00));
                else             b = 8'($urandom_range(8'h7E, 8'h20));
                push_byte(b);
            end
            serve_all(1'b1, 3);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_line_wrap();
        test_lf_no_insert();
        test_flush();
        test_reset_mid_send();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
